store_buffer: RTL
=================

# store_buffer

Posted-store buffer in the MEM stage, downstream of the EXE-stage store-data extension. It accepts each committed store (address, extended data, store type) from the pipeline and generates word-aligned address, lane-replicated write data and byte strobes. It holds up to DEPTH stores in a FIFO and drains them to data memory over a valid/ready handshake. It also reports whether a pending store overlaps a load's word address, so the hazard unit can stall loads.

## Interface
- DEPTH, 4: number of buffered stores; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_valid  in  1  pipeline presents a store this cycle.
- st_ready  out  1  buffer can accept; equals (count != DEPTH).
- st_addr  in  32  byte address of store.
- st_data  in  32  store data; relevant bits in [7:0] / [15:0] / [31:0].
- st_type  in  2  00 word, 10 halfword, 01 byte, 11 treated as word.
- st_misaligned  out  1  one-cycle pulse: the previous accepted store was misaligned and was dropped.
- mem_valid  out  1  head entry is presented to memory.
- mem_ready  in  1  memory accepts head this cycle.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated write data.
- mem_wstrb  out  4  byte enables; 4'b0000 whenever mem_valid=0.
- ld_addr  in  32  address of the load in MEM stage.
- ld_hit  out  1  combinational: some valid entry has mem_addr[31:2] == ld_addr[31:2].
- empty  out  1  count == 0 (used by fence logic).

## Operation
- Accept: st_valid && st_ready at the edge. If aligned, the entry is written at the tail, tail increments mod DEPTH, and count increments. If misaligned, nothing is written and st_misaligned=1 next cycle.
- Misaligned: halfword with addr[0]=1; word (00 or 11) with addr[1:0]!=00. Bytes are never misaligned.
- Formatting is done at enqueue and stored per entry:
  - byte: wdata={4{data[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - half: wdata={2{data[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - word: wdata=data, wstrb=4'b1111.
- Drain: mem_valid=(count!=0). mem_addr/mem_wdata/mem_wstrb come from the head entry. On mem_valid && mem_ready, head increments mod DEPTH and count decrements.
- Simultaneous accept and drain: count is unchanged, both pointers advance. When full, st_ready=0 even if mem_ready=1 that cycle (no same-cycle bypass).
- Ordering: strictly FIFO; stores drain in acceptance order.
- Head stability: while mem_valid=1 and mem_ready=0, all mem_* outputs hold stable.
- ld_hit: compares against every occupied entry, including the head being drained that cycle. It ignores an entry being enqueued that same cycle.
- Reset mid-operation: all pending stores are discarded immediately. Stores are not written to memory after reset.

## Timing
- Reset values:
  - count=0, head=tail=0.
  - mem_valid=0, mem_wstrb=0000, mem_addr=0, mem_wdata=0.
  - st_ready=1, empty=1, st_misaligned=0, ld_hit=0.
- Latency: a store accepted at edge N appears on mem_* after edge N if the buffer was empty, i.e. the earliest memory acceptance is at edge N+1.
- Throughput: one accept and one drain per cycle sustained.
- st_ready, empty and mem_valid are functions of registered count only, with no combinational path from st_valid or mem_ready.
- st_misaligned is registered: high for exactly the cycle after the offending accept.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0. Full vs empty is distinguished by count, not by pointer equality.

## Test plan
- Reset, then byte store st_addr=0x1003, st_data=0x000000AB, mem_ready=1: next cycle mem_addr=0x1000, mem_wdata=0xABABABAB, mem_wstrb=1000; one edge later empty=1.
- Halfword at 0x2002, data 0x0000BEEF: mem_wdata=0xBEEFBEEF, wstrb=1100. Word at 0x2004, data 0x12345678: wstrb=1111. Halfword at 0x2001: st_misaligned pulses once, mem_valid stays 0, count unchanged.
- mem_ready=0, push 4 stores (DEPTH=4): st_ready=0 after the 4th accept. A 5th st_valid is held. Raise mem_ready: the 4 stores drain in order on consecutive cycles, and st_ready=1 after the first drain.
- Steady stream with st_valid=1 and mem_ready=1 for 10 cycles: count stays at 1 and pointers wrap twice with no lost or duplicated store.
- Buffer holds a store to 0x3004 with mem_ready=0: ld_addr=0x3006 gives ld_hit=1, ld_addr=0x3008 gives ld_hit=0. After the drain, ld_hit=0 for 0x3006.
- Assert rst with 3 pending stores and mem_ready=0: outputs return to reset values immediately (asynchronously). After release, mem_valid stays 0 until a new store is accepted.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-store buffer: formats committed stores into word-aligned, lane-replicated
// writes with byte strobes, queues them in a FIFO and drains them to data memory.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_type,
  output logic        st_misaligned,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] occupied;

  logic [29:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [3:0]  strb_mem [DEPTH];

  logic        misaligned;
  logic [31:0] fmt_data;
  logic [3:0]  fmt_strb;
  logic        accept;
  logic        push;
  logic        pop;
  logic        unused_ld_bits;

  assign unused_ld_bits = ^ld_addr[1:0];

  // Store formatting and alignment check; type 11 falls through to word.
  always_comb begin
    misaligned = 1'b0;
    fmt_data   = st_data;
    fmt_strb   = 4'b1111;
    case (st_type)
      2'b01: begin
        fmt_data = {4{st_data[7:0]}};
        fmt_strb = 4'b0001 << st_addr[1:0];
      end
      2'b10: begin
        misaligned = st_addr[0];
        fmt_data   = {2{st_data[15:0]}};
        fmt_strb   = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: misaligned = (st_addr[1:0] != 2'b00);
    endcase
  end

  assign st_ready  = (count != CW'(DEPTH));
  assign mem_valid = (count != '0);
  assign empty     = (count == '0);
  assign accept    = st_valid && st_ready;
  assign push      = accept && !misaligned;
  assign pop       = mem_valid && mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      occupied      <= '0;
      st_misaligned <= 1'b0;
    end else begin
      st_misaligned <= accept && misaligned;
      if (pop) begin
        head           <= head + PW'(1);
        occupied[head] <= 1'b0;
      end
      if (push) begin
        tail           <= tail + PW'(1);
        occupied[tail] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy and count gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= st_addr[31:2];
      data_mem[tail] <= fmt_data;
      strb_mem[tail] <= fmt_strb;
    end
  end

  assign mem_addr  = mem_valid ? {addr_mem[head], 2'b00} : 32'h0;
  assign mem_wdata = mem_valid ? data_mem[head] : 32'h0;
  assign mem_wstrb = mem_valid ? strb_mem[head] : 4'b0000;

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i] && (addr_mem[i] == ld_addr[31:2])) ld_hit = 1'b1;
    end
  end

endmodule
